// File: rtl/dsp_pipe_reg_if.sv
// rtl/dsp_pipe_reg_if.sv - operand/result stream bundle for dsp_pipe_reg.
interface dsp_pipe_reg_if #(
  parameter int WIDTH = 18
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/dsp_pipe_reg.sv
// rtl/dsp_pipe_reg.sv - 0..4 stage pipeline register with per-stage valid, clock enable and flush.
// Optional build macro REG_PIPE_HOLD_EN: stage data loads only when the incoming valid bit is set.
module dsp_pipe_reg #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          flush,
  dsp_pipe_reg_if.slave bus
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign bus.out_data  = bus.in_data;
      assign bus.out_valid = bus.in_valid;
      assign bus.busy      = 1'b0;
    end else begin : g_pipe
      // Element 0 is the input; element k+1 is the output of stage k.
      logic [DEPTH:0][WIDTH-1:0] data_chain;
      logic [DEPTH:0]            valid_chain;

      assign data_chain[0]  = bus.in_data;
      assign valid_chain[0] = bus.in_valid;

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] data_q;
        logic             valid_q;
        logic             load;

`ifdef REG_PIPE_HOLD_EN
        assign load = valid_chain[k];
`else
        assign load = 1'b1;
`endif

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            valid_q <= 1'b0;
          end else if (flush) begin
            valid_q <= 1'b0;
          end else if (clk_en) begin
            valid_q <= valid_chain[k];
          end
        end

        // Flush clears only valid bits; data keeps following clk_en.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            data_q <= '0;
          end else if (clk_en && load) begin
            data_q <= data_chain[k];
          end
        end

        assign data_chain[k+1]  = data_q;
        assign valid_chain[k+1] = valid_q;
      end

      assign bus.out_data  = data_chain[DEPTH];
      assign bus.out_valid = valid_chain[DEPTH];
      assign bus.busy      = |valid_chain[DEPTH:1];
    end
  endgenerate

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// tb/tb_dsp_pipe_reg.sv - directed-vector bench for dsp_pipe_reg at depths 0..3.
module tb_dsp_pipe_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, rst3;
  logic ce0, ce1, ce2, ce3;
  logic fl0, fl1, fl2, fl3;

  dsp_pipe_reg_if #(.WIDTH(18)) if0 ();
  dsp_pipe_reg_if #(.WIDTH(18)) if1 ();
  dsp_pipe_reg_if #(.WIDTH(18)) if2 ();
  dsp_pipe_reg_if #(.WIDTH(18)) if3 ();

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(0)) u_d0 (.clk(clk), .rst(rst0), .clk_en(ce0), .flush(fl0), .bus(if0));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(1)) u_d1 (.clk(clk), .rst(rst1), .clk_en(ce1), .flush(fl1), .bus(if1));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst2), .clk_en(ce2), .flush(fl2), .bus(if2));
  dsp_pipe_reg #(.WIDTH(18), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst3), .clk_en(ce3), .flush(fl3), .bus(if3));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1; ce3 = 1'b1;
    fl0 = 1'b0; fl1 = 1'b0; fl2 = 1'b0; fl3 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if2.in_valid = 1'b1; if2.in_data = 18'h3FFFF;
    if3.in_valid = 1'b0; if3.in_data = '0;

    // Reset held: depth 2 must stay cleared despite a valid input.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_data", 48'(if2.out_data), 48'h0);
      check("rst_valid", 48'(if2.out_valid), 48'h0);
      check("rst_busy", 48'(if2.busy), 48'h0);
    end
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    step();
    check("rel_valid1", 48'(if2.out_valid), 48'h0);
    check("rel_busy1", 48'(if2.busy), 48'h1);
    step();
    check("rel_data", 48'(if2.out_data), 48'h3FFFF);
    check("rel_valid", 48'(if2.out_valid), 48'h1);

    // Stall: stage1=7, stage0=8, then four disabled edges.
    if2.in_data = 18'd7; step();
    if2.in_data = 18'd8; step();
    check("stall_pre", 48'(if2.out_data), 48'd7);
    ce2 = 1'b0; if2.in_data = 18'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_data", 48'(if2.out_data), 48'd7);
      check("stall_valid", 48'(if2.out_valid), 48'h1);
    end
    ce2 = 1'b1; if2.in_valid = 1'b0;
    step();
    check("stall_resume", 48'(if2.out_data), 48'd8);
    check("stall_resume_v", 48'(if2.out_valid), 48'h1);

    // Latency: beats 1..5 into depth 3.
    for (int i = 1; i <= 5; i++) begin
      if3.in_valid = 1'b1; if3.in_data = 18'(i);
      step();
      check("lat_valid", 48'(if3.out_valid), (i >= 3) ? 48'h1 : 48'h0);
      if (i >= 3) check("lat_data", 48'(if3.out_data), 48'(i - 2));
    end
    if3.in_valid = 1'b0;
    step();
    check("drain_d4", 48'(if3.out_data), 48'd4);
    step();
    check("drain_d5", 48'(if3.out_data), 48'd5);
    check("drain_busy7", 48'(if3.busy), 48'h1);
    step();
    check("drain_valid8", 48'(if3.out_valid), 48'h0);
    check("drain_busy8", 48'(if3.busy), 48'h0);

    // Flush together with stall on a full depth-3 pipe.
    if3.in_valid = 1'b1;
    if3.in_data = 18'h11; step();
    if3.in_data = 18'h22; step();
    if3.in_data = 18'h33; step();
    check("full_data", 48'(if3.out_data), 48'h11);
    check("full_busy", 48'(if3.busy), 48'h1);
    fl3 = 1'b1; ce3 = 1'b0; if3.in_data = 18'h44;
    step();
    check("flush_valid", 48'(if3.out_valid), 48'h0);
    check("flush_busy", 48'(if3.busy), 48'h0);
    check("flush_data", 48'(if3.out_data), 48'h11);
    fl3 = 1'b0; ce3 = 1'b1; if3.in_valid = 1'b0;

    // Bubble handling on depth 1.
    if1.in_valid = 1'b1; if1.in_data = 18'hA; step();
    check("bub_d0", 48'(if1.out_data), 48'hA);
    check("bub_v0", 48'(if1.out_valid), 48'h1);
    if1.in_valid = 1'b0; if1.in_data = 18'hB; step();
`ifdef REG_PIPE_HOLD_EN
    check("bub_d1", 48'(if1.out_data), 48'hA);
`else
    check("bub_d1", 48'(if1.out_data), 48'hB);
`endif
    check("bub_v1", 48'(if1.out_valid), 48'h0);
    if1.in_valid = 1'b1; if1.in_data = 18'hC; step();
    check("bub_d2", 48'(if1.out_data), 48'hC);
    check("bub_v2", 48'(if1.out_valid), 48'h1);

    // Bypass: depth 0 ignores clock, enable, flush and reset.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if0.in_data  = 18'($urandom);
      if0.in_valid = 1'($urandom);
      ce0  = 1'($urandom);
      fl0  = 1'($urandom);
      rst0 = 1'($urandom);
      #1;
      check("byp_data", 48'(if0.out_data), 48'(if0.in_data));
      check("byp_valid", 48'(if0.out_valid), 48'(if0.in_valid));
      check("byp_busy", 48'(if0.busy), 48'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dsp_pipe_reg.md
# dsp_pipe_reg

Parametrised multi-stage pipeline register with a valid bit per stage, a global clock enable and a synchronous flush. It generalises the single-stage optional operand register: one instance provides 0 to 4 register stages of any width. Valid tracking travels with the data, and the block reports when it is occupied. It sits on DSP48A1 operand and result paths (A/B/C/D/M/P) where pipeline depth is a build-time choice.

## Interface
- WIDTH, 18, data width in bits (1..48)
- DEPTH, 1, number of register stages (0..4); 0 = pure combinational bypass
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- clk_en  input  1  global stage enable; when 0, every stage holds
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  qualifies in_data
- in_data  input  WIDTH  input word
- out_valid  output  1  valid bit of last stage
- out_data  output  WIDTH  data of last stage
- busy  output  1  OR of all stage valid bits

## Operation
- Reset (rst=0, asynchronous): all stage data registers are set to 0 and all valid bits to 0. Therefore out_data=0, out_valid=0 and busy=0 until the first clock edge after release.
- The stages form a shift chain: stage0 <- input, stage k <- stage k-1, and out = stage DEPTH-1.
- Rising edge with clk_en=1 and flush=0: every stage shifts. Stage0 valid loads in_valid.
- Rising edge with clk_en=0 and flush=0: all data and valid registers hold. in_valid and in_data are ignored, so the beat presented that cycle is dropped.
- Rising edge with flush=1: every valid bit is cleared regardless of clk_en.
  - Data registers still follow the clk_en rule, so flush does not clear data.
  - The input beat sampled in that cycle is discarded (stage0 valid = 0).
- busy = OR of the stage valid bits, taken from the registers (not combinational from the inputs).
- DEPTH=0 behaves as a combinational bypass:
  - out_data = in_data and out_valid = in_valid.
  - busy is tied to 0.
  - clk_en, flush, clk and rst have no effect.
- No arithmetic is performed; data bits pass through unchanged at WIDTH bits.

## Timing
- Latency is DEPTH enabled edges. A beat presented before edge n with clk_en=1 appears on out_data/out_valid after edge n+DEPTH-1, provided clk_en was 1 on every intervening edge.
- clk_en=0 cycles stretch the latency one-for-one; nothing is lost that is already inside the pipe.
- Flush takes effect at the edge where it is sampled. out_valid=0 and busy=0 from that edge until new valid beats reach the output.
- Asserting reset in the middle of a transfer clears everything immediately without waiting for clk. Beats inside the pipe are lost.
- Reset deassertion is assumed synchronised externally. The first edge after release may capture input.

## Configuration
- REG_PIPE_HOLD_EN:
  - Defined: a stage data register loads only when the incoming valid bit is 1 (stage0: in_valid; stage k: valid of stage k-1). Bubbles therefore do not overwrite data, and each stage keeps its last valid word while its valid bit is 0.
  - Undefined: data registers shift on every edge with clk_en=1 regardless of valid. out_data during a bubble equals whatever was on in_data when the bubble entered.
- Valid-bit behaviour, latency and reset are identical in both builds.

## Test plan
- Reset: DEPTH=2, WIDTH=18. Drive in_data=18'h3FFFF, in_valid=1 and rst=0 for 3 edges -> out_data=0, out_valid=0, busy=0 throughout. rst=1 then 2 edges -> out_data=18'h3FFFF, out_valid=1.
- Latency: DEPTH=3. Present 5 consecutive beats 1,2,3,4,5 with clk_en=1 -> value 1 appears with out_valid=1 after the 3rd edge. The rest follow one per edge, and busy drops 3 edges after the last beat.
- Stall: DEPTH=2 holding beats 7 (stage1) and 8 (stage0). clk_en=0 for 4 edges -> out_data stays 7 and out_valid stays 1. clk_en=1 -> 8 appears on the next edge.
- Flush versus stall: DEPTH=3, pipe full. Assert flush=1 and clk_en=0 together for one edge -> out_valid=0 and busy=0 after that edge, and out_data is unchanged.
- Bubble data: DEPTH=1, sequence (valid,data) = (1,0xA),(0,0xB),(1,0xC). With REG_PIPE_HOLD_EN -> out_data 0xA,0xA,0xC. Without it -> 0xA,0xB,0xC. out_valid is 1,0,1 in both builds.
- Bypass: DEPTH=0. Toggle in_data, in_valid, clk_en and rst randomly for 30 cycles -> out_data==in_data and out_valid==in_valid at every sample, with busy=0.
